// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM request arbiter.
package sram_arbiter_pkg;

    localparam int unsigned DEFAULT_PORTS = 3;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ADDR_W        = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter_pick.sv
// Combinational winner selection: first requesting port at or after the pointer.
module sram_arbiter_pick #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [IDX_W-1:0]     pointer,
    output logic [IDX_W-1:0]     index,
    output logic                 valid
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;

    // Walk ports in rotated order; pointer is always below NUM_PORTS so one wrap suffices.
    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = SUM_W'(pointer) + SUM_W'(i);
            if (cand >= SUM_W'(NUM_PORTS)) begin
                cand = cand - SUM_W'(NUM_PORTS);
            end
            if (!valid && request[cand[IDX_W-1:0]]) begin
                index = cand[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port arbiter in front of a single SRAM controller.
// Define SRAM_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (port 0 highest).
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEFAULT_PORTS,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [NUM_PORTS-1:0]        i_request,
    input  logic [NUM_PORTS-1:0]        i_rw,
    input  logic [NUM_PORTS*ADDR_W-1:0] i_address,
    input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_PORTS-1:0]        o_ready,
    output logic                        m_request,
    output logic                        m_rw,
    output logic [ADDR_W-1:0]           m_address,
    output logic [DATA_W-1:0]           m_wdata,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_ready
);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_index;
    logic               pick_valid;
    logic [ADDR_W-1:0]  addr_a  [NUM_PORTS];
    logic [DATA_W-1:0]  wdata_a [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign addr_a[g]  = i_address[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = i_wdata[g*DATA_W +: DATA_W];
    end

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Pointer moves past the winner only when its transfer actually completes.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr <= '0;
        end else if (state == BUSY && m_ready) begin
            rr_ptr <= (grant == IDX_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = '0;
`endif

    sram_arbiter_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .request (i_request),
        .pointer (pick_ptr),
        .index   (pick_index),
        .valid   (pick_valid)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Completion wins over a same-cycle request drop; o_ready is a same-cycle strobe.
    always_comb begin
        next_state = state;
        o_ready    = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    o_ready[grant] = 1'b1;
                    next_state     = RELEASE;
                end else if (!i_request[grant]) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Downstream bus fields are captured once at grant and held through BUSY.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant     <= '0;
            m_request <= 1'b0;
            m_rw      <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
        end else begin
            m_request <= (next_state == BUSY);
            if (state == IDLE && pick_valid) begin
                grant     <= pick_index;
                m_rw      <= i_rw[pick_index];
                m_address <= addr_a[pick_index];
                m_wdata   <= wdata_a[pick_index];
            end
        end
    end

    assign o_rdata = m_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: transaction-level model plus directed and random traffic.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  rw = '0;
    logic [31:0] a_arr [3];
    logic [31:0] d_arr [3];
    logic [95:0] addr;
    logic [95:0] wdata;
    logic [31:0] o_rdata;
    logic [2:0]  o_ready;
    logic        m_request;
    logic        m_rw;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;

    assign addr  = {a_arr[2], a_arr[1], a_arr[0]};
    assign wdata = {d_arr[2], d_arr[1], d_arr[0]};

    sram_arbiter dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_request (req),
        .i_rw      (rw),
        .i_address (addr),
        .i_wdata   (wdata),
        .o_rdata   (o_rdata),
        .o_ready   (o_ready),
        .m_request (m_request),
        .m_rw      (m_rw),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return 0;
    endfunction

    // Transaction model: one transfer in flight, then one dead cycle before the next grant.
    bit          mdl_active = 1'b0;
    bit          mdl_gap    = 1'b0;
    int          mdl_owner  = 0;
    int          mdl_ptr    = 0;
    logic        mdl_rw     = 1'b0;
    logic [31:0] mdl_addr   = '0;
    logic [31:0] mdl_wdata  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_active = 1'b0;
            mdl_gap    = 1'b0;
            mdl_owner  = 0;
            mdl_ptr    = 0;
        end else if (mdl_active) begin
            if (m_ready) begin
                mdl_active = 1'b0;
                mdl_gap    = 1'b1;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
                mdl_ptr    = (mdl_owner + 1) % 3;
`endif
            end else if (!req[mdl_owner]) begin
                mdl_active = 1'b0;
                mdl_gap    = 1'b1;
            end
        end else if (mdl_gap) begin
            mdl_gap = 1'b0;
        end else if (req != 3'b000) begin
            mdl_owner  = pick(req, mdl_ptr);
            mdl_active = 1'b1;
            mdl_rw     = rw[mdl_owner];
            mdl_addr   = a_arr[mdl_owner];
            mdl_wdata  = d_arr[mdl_owner];
        end
    end

    logic [2:0] last_ready = '0;
    logic [2:0] exp_ready;

    always @(negedge clk) begin
        last_ready = o_ready;
        if (!rst_n) begin
            chk("rst_m_request", 32'(m_request), 32'd0);
            chk("rst_o_ready", 32'(o_ready), 32'd0);
            chk("rst_m_rw", 32'(m_rw), 32'd0);
            chk("rst_m_address", m_address, 32'd0);
            chk("rst_m_wdata", m_wdata, 32'd0);
        end else begin
            exp_ready = (mdl_active && m_ready) ? (3'b001 << mdl_owner) : 3'b000;
            chk("o_ready", 32'(o_ready), 32'(exp_ready));
            chk("m_request", 32'(m_request), 32'(mdl_active));
            chk("o_rdata", o_rdata, m_rdata);
            if (mdl_active) begin
                chk("m_rw", 32'(m_rw), 32'(mdl_rw));
                chk("m_address", m_address, mdl_addr);
                chk("m_wdata", m_wdata, mdl_wdata);
            end
        end
    end

    // Downstream controller: answers m_ready a chosen number of cycles after m_request rises.
    int          force_lat   = -1;
    logic [31:0] force_rdata = '0;
    int          lat = 0;
    int          cnt = 0;
    logic        prev_mreq = 1'b0;

    task automatic sram_drive();
        if (m_request) begin
            if (!prev_mreq) begin
                cnt = 0;
                lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
            end else begin
                cnt++;
            end
            m_ready = (cnt == lat);
            m_rdata = (force_lat >= 0) ? force_rdata : $urandom;
        end else begin
            m_ready = 1'b0;
            m_rdata = $urandom;
        end
        prev_mreq = m_request;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        sram_drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (m_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (m_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: m_ready never seen within %0d cycles", tag, n);
        end
    endtask

    int n;
    int order[$];
    int exp_order[4];

    initial begin
        for (int p = 0; p < 3; p++) begin
            a_arr[p] = '0;
            d_arr[p] = '0;
        end
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset_m_request", 32'(m_request), 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd0);
        rst_n = 1'b1;
        cyc();

        chk("pin_pick_low", 32'(pick(3'b110, 0)), 32'd1);
        chk("pin_pick_wrap", 32'(pick(3'b011, 2)), 32'd0);
        chk("pin_pick_ptr", 32'(pick(3'b101, 1)), 32'd2);

        // Read on port 1, four-cycle controller latency.
        force_lat = 4; force_rdata = 32'hDEADBEEF;
        rw[1] = 1'b0; a_arr[1] = 32'h0000_0010; req[1] = 1'b1;
        cyc();
        chk("031_m_request", 32'(m_request), 32'd1);
        chk("031_m_address", m_address, 32'h0000_0010);
        wait_ready("031_wait", n);
        chk("031_latency", 32'(n), 32'd4);
        chk("031_o_ready", 32'(o_ready), 32'b010);
        chk("031_o_rdata", o_rdata, 32'hDEADBEEF);
        req[1] = 1'b0;
        cyc();
        chk("031_release", 32'(m_request), 32'd0);
        chk("031_release_ready", 32'(o_ready), 32'd0);
        cyc();
        chk("031_idle", 32'(m_request), 32'd0);

        // Write on port 2, fields held for every busy cycle.
        force_lat = 3;
        rw[2] = 1'b1; a_arr[2] = 32'h0004_0000; d_arr[2] = 32'h1234_5678; req[2] = 1'b1;
        cyc();
        n = 0;
        while (n < 20) begin
            chk("033_m_rw", 32'(m_rw), 32'd1);
            chk("033_m_address", m_address, 32'h0004_0000);
            chk("033_m_wdata", m_wdata, 32'h1234_5678);
            if (m_ready) break;
            cyc();
            n++;
        end
        chk("033_o_ready", 32'(o_ready), 32'b100);
        req[2] = 1'b0;
        cyc();
        cyc();

        // All three ports request continuously.
        do_reset();
        force_lat = 1;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int p = 0; p < 3; p++) begin
            a_arr[p] = 32'h1000 * (p + 1);
            d_arr[p] = 32'hA0 + p;
        end
        rw  = 3'b000;
        req = 3'b111;
        n = 0;
        while (order.size() < 4 && n < 40) begin
            cyc();
            n++;
            for (int k = 0; k < 3; k++) begin
                if (o_ready[k]) order.push_back(k);
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("032_grant%0d", i), 32'(order.size() > i ? order[i] : -1), 32'(exp_order[i]));
        end
        req = '0;
        cyc();
        cyc();

        // Granted port 0 abandons its transfer after two busy cycles.
        do_reset();
        force_lat = 10;
        a_arr[0] = 32'h100; a_arr[1] = 32'h200;
        req = 3'b011;
        cyc();
        chk("034_grant0", m_address, 32'h100);
        cyc();
        req[0] = 1'b0;
        cyc();
        chk("034_release", 32'(m_request), 32'd0);
        chk("034_no_ready", 32'(o_ready), 32'd0);
        force_lat = 1;
        cyc();
        chk("034_idle", 32'(m_request), 32'd0);
        cyc();
        chk("034_regrant", 32'(m_request), 32'd1);
        chk("034_regrant_addr", m_address, 32'h200);
        wait_ready("034_wait", n);
        chk("034_o_ready", 32'(o_ready), 32'b010);
        req = '0;
        cyc();
        cyc();

        // Completion and request drop in the same cycle.
        do_reset();
        force_lat = 2;
        a_arr[0] = 32'h300; a_arr[1] = 32'h400;
        req = 3'b001;
        cyc();
        wait_ready("036_wait", n);
        req[0] = 1'b0;
        #1;
        chk("036_pulse", 32'(o_ready), 32'b001);
        cyc();
        chk("036_single", 32'(o_ready), 32'd0);
        cyc();
        force_lat = 1;
        req = 3'b011;
        cyc();
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
        chk("036_ptr_adv", m_address, 32'h400);
`else
        chk("036_fixed", m_address, 32'h300);
`endif
        wait_ready("036_wait2", n);
        cyc();
        req = '0;
        cyc();
        cyc();

        // Reset pulse while busy, held request re-granted afterwards.
        do_reset();
        force_lat = 10;
        a_arr[2] = 32'h500;
        req = 3'b100;
        cyc();
        chk("035_busy", 32'(m_request), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("035_m_request", 32'(m_request), 32'd0);
        chk("035_o_ready", 32'(o_ready), 32'd0);
        cyc();
        cyc();
        force_lat = 1;
        rst_n = 1'b1;
        cyc();
        chk("026_first_grant", 32'(m_request), 32'd1);
        chk("026_grant_addr", m_address, 32'h500);
        wait_ready("035_wait", n);
        chk("035_o_ready_done", 32'(o_ready), 32'b100);
        req = '0;
        cyc();
        cyc();

        // Random traffic with occasional aborts by the granted port.
        do_reset();
        force_lat = -1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int p = 0; p < 3; p++) begin
                if (req[p] && last_ready[p]) begin
                    req[p] = 1'b0;
                end else if (req[p] && mdl_active && mdl_owner == p && $urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end else if (!req[p] && $urandom_range(0, 3) == 0) begin
                    rw[p]    = 1'($urandom);
                    a_arr[p] = $urandom;
                    d_arr[p] = $urandom;
                    req[p]   = 1'b1;
                end
            end
        end
        req = '0;
        cyc();
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, meaning number of requester ports (2..8).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_PORTS), meaning width of the grant index.
REQ-003 SHALL have port i_clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_request  input  NUM_PORTS  per-port request, held until that port's o_ready.
REQ-006 SHALL have port i_rw  input  NUM_PORTS  per-port direction: 1 = write, 0 = read.
REQ-007 SHALL have port i_address  input  NUM_PORTS x 32  per-port byte address.
REQ-008 SHALL have port i_wdata  input  NUM_PORTS x 32  per-port write data.
REQ-009 SHALL have port o_rdata  output  32  read data, shared by all ports, valid with o_ready.
REQ-010 SHALL have port o_ready  output  NUM_PORTS  one-hot completion strobe.
REQ-011 SHALL have ports m_request, m_rw, m_address[31:0], m_wdata[31:0]  output  downstream SRAM controller request bus.
REQ-012 SHALL have ports m_rdata[31:0], m_ready  input  downstream SRAM controller response.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, RELEASE.
REQ-014 IDLE: if any i_request is high, SHALL pick a winner, register grant index, latch its i_rw, i_address and i_wdata into m_* registers, and go to BUSY next edge.
REQ-015 BUSY: m_request SHALL be 1; the m_* fields SHALL stay constant.
REQ-016 BUSY with m_ready=1: o_ready[grant] SHALL be 1 in the same cycle (combinational), o_rdata=m_rdata; next state RELEASE.
REQ-017 RELEASE: m_request SHALL be 0 for exactly one cycle, so the downstream cycle counter clears; next state IDLE.
REQ-018 Request-to-m_request latency SHALL be 1 cycle; minimum gap between back-to-back grants SHALL be 2 cycles (RELEASE + IDLE).
REQ-019 o_ready SHALL be 0 for all non-granted ports and in IDLE and RELEASE.
REQ-020 Abort: granted port drops i_request in BUSY without m_ready -> next state RELEASE, no o_ready pulse, pointer unchanged.
REQ-021 Simultaneous: m_ready and granted i_request falling in the same cycle SHALL count as completion (o_ready pulses).
REQ-022 Requests arriving in BUSY or RELEASE SHALL wait; none are lost, since requests are level-held.
REQ-023 o_rdata SHALL drive m_rdata in all states; requesters sample it only with o_ready.

Reset
REQ-024 Asserting i_reset_n low SHALL immediately force state IDLE, m_request=0, m_rw=0, m_address=0, m_wdata=0, grant=0, rr pointer=0, o_ready=0.
REQ-025 Reset mid-BUSY SHALL drop m_request asynchronously, and no o_ready SHALL be issued for the aborted transfer.
REQ-026 After i_reset_n rises, the first arbitration SHALL occur on the first rising edge at which i_request is nonzero.

Configuration
REQ-027 With SRAM_ARBITER_ROUND_ROBIN_EN defined: winner SHALL be the first requesting port at or after the rr pointer, wrapping NUM_PORTS-1 -> 0; on completion only, the pointer SHALL become grant+1 (mod NUM_PORTS).
REQ-028 Without SRAM_ARBITER_ROUND_ROBIN_EN: fixed priority, lowest index wins; the pointer register SHALL not exist.

Structure
REQ-029 Package sram_arbiter_pkg SHALL hold the state enum (IDLE, BUSY, RELEASE) and a default-ports constant of 3.
REQ-030 Winner selection SHALL live in sub-module sram_arbiter_pick (inputs: request vector and pointer; outputs: index and valid), purely combinational.

Verification
REQ-031 Read on port 1, addr 0x0000_0010, downstream m_ready 4 cycles after m_request with m_rdata 0xDEADBEEF -> m_request high 1 cycle after i_request[1], o_ready=3'b010 for 1 cycle, o_rdata=0xDEADBEEF, then m_request low 1 cycle.
REQ-032 Ports 0, 1 and 2 request together continuously, round robin -> grant order 0,1,2,0; fixed priority -> 0,0,0 while port 0 stays asserted.
REQ-033 Write on port 2, wdata 0x12345678, addr 0x0004_0000 -> m_rw=1, m_wdata=0x12345678, m_address=0x0004_0000 held stable for all BUSY cycles.
REQ-034 Port 0 drops i_request 2 cycles into BUSY -> no o_ready, RELEASE for 1 cycle, pending port 1 granted 2 cycles later.
REQ-035 i_reset_n pulsed low in BUSY -> m_request=0 in the same cycle, o_ready=0, state IDLE; the held request is re-granted after release.
REQ-036 m_ready on the same cycle that granted i_request falls -> single o_ready pulse, pointer advances.
